// File: rtl/spi_i2s_ipi_clk_arb.sv
// rtl/spi_i2s_ipi_clk_arb.sv - round-robin SPI/I2S arbiter for a shared clock divider
// Optional watchdog: define SPI_I2S_IPI_CLK_ARB_TIMEOUT_EN.
module spi_i2s_ipi_clk_arb #(
    parameter int PARAM_SEL_WIDTH  = 3,
    parameter int PARAM_EDGE_WIDTH = 6,
    parameter int PARAM_TMO_CYCLES = 1024
) (
    input  logic                        clka_clk,
    input  logic                        clka_rst,
    input  logic [1:0]                  clka_req_i,
    input  logic [PARAM_SEL_WIDTH-1:0]  clka_div_sel0_i,
    input  logic [PARAM_SEL_WIDTH-1:0]  clka_div_sel1_i,
    input  logic [PARAM_EDGE_WIDTH-1:0] clka_edges0_i,
    input  logic [PARAM_EDGE_WIDTH-1:0] clka_edges1_i,
    input  logic                        clka_time_base_i,
    output logic [1:0]                  clka_gnt_o,
    output logic [PARAM_SEL_WIDTH-1:0]  clka_div_sel_o,
    output logic                        clka_div_en_o,
    output logic [1:0]                  clka_done_o,
    output logic                        clka_busy_o,
    output logic                        clka_err_o
);

    typedef enum logic [1:0] {IDLE, SETUP, RUN, DONE} state_t;

    localparam logic [PARAM_EDGE_WIDTH-1:0] EDGE_ONE = 1;

    state_t                      state;
    logic                        last;
    logic [PARAM_EDGE_WIDTH-1:0] edges_q;
    logic [PARAM_EDGE_WIDTH-1:0] cnt;

    logic                        win;
    logic [PARAM_SEL_WIDTH-1:0]  win_sel;
    logic [PARAM_EDGE_WIDTH-1:0] win_edges;
    logic                        owner_req;

`ifdef SPI_I2S_IPI_CLK_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(PARAM_TMO_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(PARAM_TMO_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_ONE  = 1;
    logic [WD_W-1:0] wd;
`endif

    // With both requesting, the one not granted last wins; last resets to 1 so bit0 goes first.
    always_comb begin
        win       = (clka_req_i == 2'b11) ? ~last : clka_req_i[1];
        win_sel   = win ? clka_div_sel1_i : clka_div_sel0_i;
        win_edges = win ? clka_edges1_i : clka_edges0_i;
        owner_req = |(clka_req_i & clka_gnt_o);
    end

    always_ff @(posedge clka_clk or posedge clka_rst) begin
        if (clka_rst) begin
            state          <= IDLE;
            last           <= 1'b1;
            edges_q        <= '0;
            cnt            <= '0;
            clka_gnt_o     <= '0;
            clka_div_sel_o <= '0;
            clka_div_en_o  <= 1'b0;
            clka_done_o    <= '0;
            clka_busy_o    <= 1'b0;
`ifdef SPI_I2S_IPI_CLK_ARB_TIMEOUT_EN
            clka_err_o     <= 1'b0;
            wd             <= '0;
`endif
        end else begin
            clka_done_o <= '0;
`ifdef SPI_I2S_IPI_CLK_ARB_TIMEOUT_EN
            clka_err_o  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (|clka_req_i) begin
                        state          <= SETUP;
                        clka_gnt_o     <= win ? 2'b10 : 2'b01;
                        last           <= win;
                        clka_div_sel_o <= win_sel;
                        edges_q        <= win_edges;
                        clka_busy_o    <= 1'b1;
                    end
                end
                SETUP: begin
                    if (!owner_req) begin
                        state       <= IDLE;
                        clka_gnt_o  <= '0;
                        clka_busy_o <= 1'b0;
                    end else if (edges_q == '0) begin
                        state       <= DONE;
                        clka_done_o <= clka_gnt_o;
                    end else begin
                        state         <= RUN;
                        clka_div_en_o <= 1'b1;
                        cnt           <= '0;
`ifdef SPI_I2S_IPI_CLK_ARB_TIMEOUT_EN
                        wd            <= '0;
`endif
                    end
                end
                RUN: begin
                    if (!owner_req) begin
                        state         <= IDLE;
                        clka_gnt_o    <= '0;
                        clka_busy_o   <= 1'b0;
                        clka_div_en_o <= 1'b0;
                    end else if (clka_time_base_i) begin
`ifdef SPI_I2S_IPI_CLK_ARB_TIMEOUT_EN
                        wd <= '0;
`endif
                        if (cnt == edges_q - EDGE_ONE) begin
                            state         <= DONE;
                            clka_div_en_o <= 1'b0;
                            clka_done_o   <= clka_gnt_o;
                        end else begin
                            cnt <= cnt + EDGE_ONE;
                        end
                    end
`ifdef SPI_I2S_IPI_CLK_ARB_TIMEOUT_EN
                    else if (wd == WD_LAST) begin
                        state         <= IDLE;
                        clka_gnt_o    <= '0;
                        clka_busy_o   <= 1'b0;
                        clka_div_en_o <= 1'b0;
                        clka_err_o    <= 1'b1;
                    end else begin
                        wd <= wd + WD_ONE;
                    end
`endif
                end
                DONE: begin
                    state       <= IDLE;
                    clka_gnt_o  <= '0;
                    clka_busy_o <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef SPI_I2S_IPI_CLK_ARB_TIMEOUT_EN
    assign clka_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_spi_i2s_ipi_clk_arb.sv
// tb/tb_spi_i2s_ipi_clk_arb.sv - directed and randomized checks of spi_i2s_ipi_clk_arb against a transaction model
module tb_spi_i2s_ipi_clk_arb;

    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req = '0;
    logic [2:0] sel0 = '0, sel1 = '0;
    logic [5:0] edg0 = '0, edg1 = '0;
    logic       tbase = 1'b0;
    logic [1:0] gnt;
    logic [2:0] div_sel;
    logic       div_en;
    logic [1:0] done;
    logic       busy;
    logic       err;

    int n_checks = 0;
    int n_pass   = 0;

    spi_i2s_ipi_clk_arb #(
        .PARAM_SEL_WIDTH (3),
        .PARAM_EDGE_WIDTH(6),
        .PARAM_TMO_CYCLES(TMO)
    ) dut (
        .clka_clk        (clk),
        .clka_rst        (rst),
        .clka_req_i      (req),
        .clka_div_sel0_i (sel0),
        .clka_div_sel1_i (sel1),
        .clka_edges0_i   (edg0),
        .clka_edges1_i   (edg1),
        .clka_time_base_i(tbase),
        .clka_gnt_o      (gnt),
        .clka_div_sel_o  (div_sel),
        .clka_div_en_o   (div_en),
        .clka_done_o     (done),
        .clka_busy_o     (busy),
        .clka_err_o      (err)
    );

    always #5 clk = ~clk;

    // Transaction model: who owns the divider, whether this is the setup cycle, pulses still owed.
    int         m_owner;
    bit         m_setup;
    int         m_left;
    int         m_last;
    int         m_wd;
    bit         m_err;
    logic [2:0] m_sel;

    task automatic model_reset();
        m_owner = -1; m_setup = 0; m_left = 0; m_last = 1; m_wd = 0; m_err = 0; m_sel = '0;
    endtask

    task automatic model_step(input logic [1:0] r, input logic t,
                              input logic [2:0] s0, input logic [2:0] s1,
                              input logic [5:0] e0, input logic [5:0] e1);
        int w;
        m_err = 0;
        if (m_owner < 0) begin
            if (r != 2'b00) begin
                w = (r == 2'b11) ? 1 - m_last : (r[1] ? 1 : 0);
                m_owner = w; m_last = w; m_setup = 1;
                m_left = w ? int'(e1) : int'(e0);
                m_sel  = w ? s1 : s0;
            end
        end else if (!m_setup && m_left == 0) begin
            m_owner = -1;
        end else if (!r[m_owner]) begin
            m_owner = -1;
        end else if (m_setup) begin
            m_setup = 0; m_wd = 0;
        end else if (t) begin
            m_left = m_left - 1; m_wd = 0;
        end else begin
            m_wd = m_wd + 1;
`ifdef SPI_I2S_IPI_CLK_ARB_TIMEOUT_EN
            if (m_wd == TMO) begin
                m_owner = -1; m_err = 1;
            end
`endif
        end
    endtask

    function automatic logic [9:0] model_vec();
        logic [1:0] g;
        logic       en, dn;
        g  = (m_owner < 0) ? 2'b00 : ((m_owner == 1) ? 2'b10 : 2'b01);
        en = (m_owner >= 0) && !m_setup && (m_left > 0);
        dn = (m_owner >= 0) && !m_setup && (m_left == 0);
        return {g, m_sel, en, dn ? g : 2'b00, m_owner >= 0, m_err};
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    endtask

    task automatic tick(input logic [1:0] r, input logic t,
                        input logic [2:0] s0, input logic [2:0] s1,
                        input logic [5:0] e0, input logic [5:0] e1);
        logic [9:0] exp_v, got_v;
        req = r; tbase = t; sel0 = s0; sel1 = s1; edg0 = e0; edg1 = e1;
        model_step(r, t, s0, s1, e0, e1);
        @(posedge clk);
        #1;
        exp_v = model_vec();
        got_v = {gnt, div_sel, div_en, done, busy, err};
        n_checks++;
        if (got_v === exp_v) n_pass++;
        else $display("FAIL model {gnt,sel,en,done,busy,err}: got %b expected %b at %0t", got_v, exp_v, $time);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        chk("reset_outputs", int'({gnt, div_sel, div_en, done, busy, err}), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int first;
        int ng;
        int grants[3];
        logic [1:0] prev_g;
        logic [1:0] rq;

        model_reset();
        @(posedge clk);
        #1;
        apply_reset();

        // /8 divider: one time-base pulse every 8 RUN cycles, four pulses owed.
        tick(2'b01, 1'b0, 3'd2, 3'd0, 6'd4, 6'd0);
        chk("r33_gnt_n1", int'(gnt), 1);
        chk("r33_en_n1", int'(div_en), 0);
        tick(2'b01, 1'b0, 3'd2, 3'd0, 6'd4, 6'd0);
        chk("r33_en_n2", int'(div_en), 1);
        chk("r33_sel", int'(div_sel), 2);
        first = -1;
        for (int k = 0; k < 40 && first < 0; k++) begin
            tick(2'b01, (k % 8) == 7, 3'd2, 3'd0, 6'd4, 6'd0);
            if (done != 2'b00) first = k;
        end
        chk("r33_done_cycle", first, 31);
        chk("r33_done_val", int'(done), 1);
        chk("r33_en_done", int'(div_en), 0);
        tick(2'b00, 1'b0, 3'd0, 3'd0, 6'd0, 6'd0);
        chk("r33_gnt_clear", int'(gnt), 0);

        // Alternation from reset with both requesting continuously.
        apply_reset();
        ng = 0;
        prev_g = 2'b00;
        for (int k = 0; k < 40; k++) begin
            tick(2'b11, 1'b1, 3'd1, 3'd3, 6'd3, 6'd3);
            if (prev_g == 2'b00 && gnt != 2'b00 && ng < 3) begin
                grants[ng] = int'(gnt);
                ng++;
            end
            prev_g = gnt;
        end
        chk("r34_ngrants", ng, 3);
        chk("r34_g0", grants[0], 1);
        chk("r34_g1", grants[1], 2);
        chk("r34_g2", grants[2], 1);

        // Zero-edge transaction: SETUP then DONE, divider never enabled.
        for (int k = 0; k < 3; k++) tick(2'b00, 1'b0, 3'd0, 3'd0, 6'd0, 6'd0);
        tick(2'b10, 1'b1, 3'd0, 3'd5, 6'd0, 6'd0);
        chk("r35_gnt", int'(gnt), 2);
        tick(2'b10, 1'b1, 3'd0, 3'd5, 6'd0, 6'd0);
        chk("r35_done", int'(done), 2);
        chk("r35_en", int'(div_en), 0);
        tick(2'b00, 1'b0, 3'd0, 3'd0, 6'd0, 6'd0);
        chk("r35_idle_gnt", int'(gnt), 0);

        // Abort after two of five pulses.
        tick(2'b01, 1'b0, 3'd4, 3'd0, 6'd5, 6'd0);
        tick(2'b01, 1'b0, 3'd4, 3'd0, 6'd5, 6'd0);
        tick(2'b01, 1'b1, 3'd4, 3'd0, 6'd5, 6'd0);
        tick(2'b01, 1'b1, 3'd4, 3'd0, 6'd5, 6'd0);
        chk("r36_en_before", int'(div_en), 1);
        tick(2'b00, 1'b1, 3'd4, 3'd0, 6'd5, 6'd0);
        chk("r36_abort", int'({gnt, div_en, done, busy}), 0);

        // Asynchronous reset mid-RUN, then a fresh request.
        tick(2'b10, 1'b0, 3'd0, 3'd6, 6'd0, 6'd5);
        tick(2'b10, 1'b0, 3'd0, 3'd6, 6'd0, 6'd5);
        tick(2'b10, 1'b1, 3'd0, 3'd6, 6'd0, 6'd5);
        chk("r37_in_run", int'(div_en), 1);
        #2;
        apply_reset();
        tick(2'b10, 1'b0, 3'd0, 3'd6, 6'd0, 6'd5);
        chk("r37_regrant", int'(gnt), 2);
        tick(2'b00, 1'b0, 3'd0, 3'd0, 6'd0, 6'd0);

        // Time base held low in RUN.
        tick(2'b00, 1'b0, 3'd0, 3'd0, 6'd0, 6'd0);
        tick(2'b01, 1'b0, 3'd0, 3'd0, 6'd5, 6'd0);
        tick(2'b01, 1'b0, 3'd0, 3'd0, 6'd5, 6'd0);
        first = -1;
        for (int k = 0; k < 20; k++) begin
            tick(2'b01, 1'b0, 3'd0, 3'd0, 6'd5, 6'd0);
            if (err && first < 0) first = k;
        end
`ifdef SPI_I2S_IPI_CLK_ARB_TIMEOUT_EN
        chk("r38_err_cycle", first, TMO - 1);
        chk("r38_gnt_after", int'(gnt), 0);
`else
        chk("r38_no_err", first, -1);
        chk("r38_still_run", int'(div_en), 1);
`endif
        tick(2'b00, 1'b0, 3'd0, 3'd0, 6'd0, 6'd0);
        tick(2'b00, 1'b0, 3'd0, 3'd0, 6'd0, 6'd0);

        // Randomized traffic: mostly-held requests, random pulses, inputs wiggling mid-transaction.
        rq = 2'b00;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 9) == 0) rq[0] = ~rq[0];
            if ($urandom_range(0, 9) == 0) rq[1] = ~rq[1];
            tick(rq, $urandom_range(0, 2) == 0,
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 6'($urandom_range(0, 4)), 6'($urandom_range(0, 4)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
